st2_loader: RTL and testbench

Cartridge loader feeding the `rcastudioii` core's cartridge RAM from the HPS/sim `ioctl_*` download stream. It accepts either a raw binary (index 0) or a `.st2` image (index 1) and parses the `.st2` header and page table. Writes are buffered through a small FIFO to a back-pressurable memory write port, and `ioctl_wait` throttles the source. The core is held in reset for the whole load.

---
 rtl/studio2_pkg.sv | 35 +++
 rtl/st2_loader_if.sv | 25 ++
 rtl/loader_fifo.sv | 67 ++++++
 rtl/st2_loader.sv | 221 ++++++++++++++++++++++
 tb/tb_st2_loader.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/studio2_pkg.sv
// Shared definitions for the Studio II cartridge loader.
// Holds the loader state encoding, the .st2 header layout constants
// and the default raw-image load address and size limit.
package studio2_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HEADER,
        ST_DATA,
        ST_FLUSH,
        ST_DONE,
        ST_ERROR
    } loader_state_t;

    localparam logic [31:0] ST2_MAGIC        = 32'h52434132;  // "RCA2"
    localparam int unsigned ST2_HDR_BYTES    = 256;
    localparam int unsigned ST2_PAGE_OFS     = 64;
    localparam int unsigned ST2_PAGE_ENTRIES = 63;

    localparam logic [11:0] RAW_BASE_DEFAULT = 12'h400;
    localparam int unsigned RAW_MAX_DEFAULT  = 1024;

    // Expected header byte at file offsets 0..3 (offset 0 is the first character).
    function automatic logic [7:0] st2_magic_byte(input logic [1:0] idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = ST2_MAGIC[31:24];
            2'd1:    b = ST2_MAGIC[23:16];
            2'd2:    b = ST2_MAGIC[15:8];
            default: b = ST2_MAGIC[7:0];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/st2_loader_if.sv
// Cartridge RAM write port used by the loader.
//   mem_addr  : 12-bit write address (driven by master)
//   mem_data  : 8-bit write data     (driven by master)
//   mem_we    : write request, held until accepted (driven by master)
//   mem_ready : RAM accepts the write this cycle (driven by slave)
interface st2_loader_if;
    logic [11:0] mem_addr;
    logic [7:0]  mem_data;
    logic        mem_we;
    logic        mem_ready;

    modport master (
        output mem_addr,
        output mem_data,
        output mem_we,
        input  mem_ready
    );

    modport slave (
        input  mem_addr,
        input  mem_data,
        input  mem_we,
        output mem_ready
    );
endinterface

// File: rtl/loader_fifo.sv
// Small synchronous FIFO buffering loader writes ({addr12, data8}).
//   clk, reset : clock, asynchronous active-high reset (storage cleared too)
//   clear      : synchronous flush, drops all entries
//   push, din  : enqueue (ignored when full)
//   pop, dout  : dequeue; dout is the current head (show-ahead)
//   full, empty, count : occupancy status
module loader_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 20
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clear,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] store [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                store[i] <= '0;
            end
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                store[wr_ptr] <= din;
                wr_ptr        <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (do_push && !do_pop) begin
                count <= count + CW'(1);
            end else if (do_pop && !do_push) begin
                count <= count - CW'(1);
            end
        end
    end

    assign dout  = store[rd_ptr];
    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/st2_loader.sv
// Studio II cartridge loader: turns the ioctl download stream (raw binary
// on index 0, .st2 image on index 1) into cartridge RAM writes, holding the
// core in reset for the whole load.
//   clk, reset     : clock, asynchronous active-high reset
//   ioctl_download : download window
//   ioctl_wr       : byte strobe, with ioctl_addr (file offset) / ioctl_dout
//   ioctl_index    : 0 raw, 1 .st2, anything else rejected
//   ioctl_wait     : throttle request to the source
//   mem            : cartridge RAM write port (mem_addr/mem_data/mem_we/mem_ready)
//   core_reset     : reset to the core, released only after a clean load
//   load_done      : last load completed cleanly
//   load_error     : last load was rejected
module st2_loader
    import studio2_pkg::*;
#(
    parameter logic [11:0] RAW_BASE   = RAW_BASE_DEFAULT,
    parameter int unsigned RAW_MAX    = RAW_MAX_DEFAULT,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               ioctl_download,
    input  logic               ioctl_wr,
    input  logic [24:0]        ioctl_addr,
    input  logic [7:0]         ioctl_dout,
    input  logic [7:0]         ioctl_index,
    output logic               ioctl_wait,
    st2_loader_if.master       mem,
    output logic               core_reset,
    output logic               load_done,
    output logic               load_error
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0] WAIT_LEVEL = CW'(FIFO_DEPTH - 1);

    loader_state_t state;
    loader_state_t state_next;

    logic          dl_q;
    logic          dl_rise;
    logic          dl_fall;
    logic          load_start;
    logic          mode_st2;
    logic [7:0]    nblocks;
    logic [7:0]    page [ST2_PAGE_ENTRIES];

    logic [31:0]   ofs;
    logic [5:0]    blk;
    logic [5:0]    blk_k;
    logic [7:0]    page_sel;
    logic          page_hi_unused;
    logic [5:0]    page_idx;
    logic          magic_bad;
    logic [11:0]   wr_addr;
    logic          drop;

    logic          push;
    logic          pop;
    logic          fifo_clear;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;
    logic [CW-1:0] count_next;
    logic [19:0]   fifo_dout;

    assign dl_rise    = ioctl_download && !dl_q;
    assign dl_fall    = !ioctl_download && dl_q;
    assign load_start = dl_rise && (state inside {ST_IDLE, ST_DONE, ST_ERROR});

    // Address decode for header capture and DATA-phase mapping.
    always_comb begin
        ofs       = {7'b0, ioctl_addr};
        blk       = ioctl_addr[13:8];
        blk_k     = blk - 6'd1;
        page_sel  = (blk_k < 6'(ST2_PAGE_ENTRIES)) ? page[blk_k] : '0;
        page_idx  = 6'(ofs - ST2_PAGE_OFS);
        magic_bad = (ofs < 32'd4) && (ioctl_dout != st2_magic_byte(ioctl_addr[1:0]));
        if (mode_st2) begin
            wr_addr = {page_sel[3:0], ioctl_addr[7:0]};
            // blk >= nblocks is k >= nblocks-1; blk == 0 would wrap k to 63.
            drop    = (ioctl_addr[24:14] != '0) || (blk == '0) || ({2'b00, blk} >= nblocks);
        end else begin
            wr_addr = RAW_BASE + ioctl_addr[11:0];
            drop    = (ofs >= RAW_MAX);
        end
    end

    assign page_hi_unused = ^page_sel[7:4];

    // FIFO control
    assign push        = (state == ST_DATA) && ioctl_wr && !fifo_full && !drop;
    assign fifo_clear  = (state == ST_ERROR);
    assign mem.mem_we  = !fifo_empty && (state != ST_ERROR);
    assign pop         = mem.mem_we && mem.mem_ready;
    assign mem.mem_addr = fifo_dout[19:8];
    assign mem.mem_data = fifo_dout[7:0];

    always_comb begin
        count_next = fifo_count;
        if (fifo_clear) begin
            count_next = '0;
        end else if (push && !pop) begin
            count_next = fifo_count + CW'(1);
        end else if (pop && !push) begin
            count_next = fifo_count - CW'(1);
        end
    end

    loader_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (20)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .clear (fifo_clear),
        .push  (push),
        .din   ({wr_addr, ioctl_dout}),
        .pop   (pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // FSM: state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM: next state
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (dl_rise) begin
                    if (ioctl_index == 8'd0) begin
                        state_next = ST_DATA;
                    end else if (ioctl_index == 8'd1) begin
                        state_next = ST_HEADER;
                    end else begin
                        state_next = ST_ERROR;
                    end
                end
            end
            ST_HEADER: begin
                if (dl_fall) begin
                    state_next = ST_ERROR;
                end else if (ioctl_wr) begin
                    if (magic_bad) begin
                        state_next = ST_ERROR;
                    end else if (ofs == ST2_HDR_BYTES - 1) begin
                        state_next = (nblocks < 8'd2) ? ST_ERROR : ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (ioctl_wr && fifo_full) begin
                    state_next = ST_ERROR;
                end else if (dl_fall) begin
                    state_next = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                // Look at the post-pop occupancy so DONE follows the last pop by one cycle.
                if (count_next == '0) begin
                    state_next = ST_DONE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        core_reset = 1'b1;
        load_done  = 1'b0;
        load_error = 1'b0;
        case (state)
            ST_DONE: begin
                core_reset = 1'b0;
                load_done  = 1'b1;
            end
            ST_ERROR: load_error = 1'b1;
            default: ;
        endcase
    end

    // Edge detect, mode, header capture and throttle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dl_q       <= 1'b0;
            mode_st2   <= 1'b0;
            nblocks    <= '0;
            ioctl_wait <= 1'b0;
            for (int unsigned i = 0; i < ST2_PAGE_ENTRIES; i++) begin
                page[i] <= '0;
            end
        end else begin
            dl_q       <= ioctl_download;
            ioctl_wait <= (count_next >= WAIT_LEVEL);
            if (load_start) begin
                mode_st2 <= (ioctl_index == 8'd1);
                nblocks  <= '0;
            end
            if ((state == ST_HEADER) && ioctl_wr) begin
                if (ofs == 32'd4) begin
                    nblocks <= ioctl_dout;
                end
                if ((ofs >= ST2_PAGE_OFS) && (ofs < ST2_PAGE_OFS + ST2_PAGE_ENTRIES)) begin
                    page[page_idx] <= ioctl_dout;
                end
            end
        end
    end

endmodule

// File: tb/tb_st2_loader.sv
module tb_st2_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        ioctl_download;
    logic        ioctl_wr;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout;
    logic [7:0]  ioctl_index;
    logic        ioctl_wait;
    logic        core_reset;
    logic        load_done;
    logic        load_error;

    st2_loader_if mem_if ();

    st2_loader #(
        .RAW_BASE   (12'h400),
        .RAW_MAX    (1024),
        .FIFO_DEPTH (4)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .ioctl_download (ioctl_download),
        .ioctl_wr       (ioctl_wr),
        .ioctl_addr     (ioctl_addr),
        .ioctl_dout     (ioctl_dout),
        .ioctl_index    (ioctl_index),
        .ioctl_wait     (ioctl_wait),
        .mem            (mem_if),
        .core_reset     (core_reset),
        .load_done      (load_done),
        .load_error     (load_error)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int we_cycles = 0;
    logic [19:0] wlog [$];

    // Record every accepted RAM write and every cycle with a write request.
    always @(negedge clk) begin
        if (mem_if.mem_we === 1'b1) begin
            we_cycles++;
            if (mem_if.mem_ready === 1'b1) begin
                wlog.push_back({mem_if.mem_addr, mem_if.mem_data});
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed no completion, expected finish before timeout");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic start_load(input logic [7:0] idx);
        ioctl_index    = idx;
        ioctl_download = 1'b1;
        tick(1);
    endtask

    task automatic put(input int ofs, input logic [7:0] b);
        ioctl_wr   = 1'b1;
        ioctl_addr = 25'(ofs);
        ioctl_dout = b;
        tick(1);
        ioctl_wr   = 1'b0;
    endtask

    function automatic logic [7:0] hdr_byte(input int i, input logic [31:0] magic);
        if (i < 4)   return magic[31 - 8*i -: 8];
        if (i == 4)  return 8'd3;
        if (i == 64) return 8'h04;
        if (i == 65) return 8'h06;
        return 8'h00;
    endfunction

    initial begin
        int bad;
        int sent;
        logic [11:0] ea;
        logic [7:0]  ed;

        reset          = 1'b1;
        ioctl_download = 1'b0;
        ioctl_wr       = 1'b0;
        ioctl_addr     = '0;
        ioctl_dout     = '0;
        ioctl_index    = '0;
        mem_if.mem_ready = 1'b1;
        tick(2);

        // Reset state
        check("rst_wait",       ioctl_wait, 0);
        check("rst_mem_we",     mem_if.mem_we, 0);
        check("rst_load_done",  load_done, 0);
        check("rst_load_error", load_error, 0);
        check("rst_core_reset", core_reset, 1);
        check("rst_mem_bus",    {mem_if.mem_addr, mem_if.mem_data}, 0);
        reset = 1'b0;
        tick(1);

        // Raw load 0..1024, byte = offset[7:0]
        wlog.delete();
        start_load(8'd0);
        check("raw_core_reset_busy", core_reset, 1);
        for (int i = 0; i <= 1024; i++) put(i, i[7:0]);
        ioctl_download = 1'b0;
        check("raw_core_reset_edge", core_reset, 1);
        tick(1);
        check("raw_core_reset_1", core_reset, 1);
        tick(1);
        check("raw_core_reset_2", core_reset, 0);
        check("raw_load_done", load_done, 1);
        check("raw_count", wlog.size(), 1024);
        bad = 0;
        for (int i = 0; i < wlog.size(); i++) begin
            ea = 12'h400 + 12'(i);
            ed = 8'(i);
            if (wlog[i] !== {ea, ed}) bad++;
        end
        check("raw_stream", bad, 0);
        if (wlog.size() == 1024) check("raw_last", wlog[1023], {12'h7FF, 8'hFF});

        // .st2 load: nblocks=3, page[0]=04, page[1]=06
        wlog.delete();
        ioctl_index    = 8'd1;
        ioctl_download = 1'b1;
        check("st2_core_reset_pre", core_reset, 0);
        tick(1);
        check("st2_core_reset_rise", core_reset, 1);
        check("st2_done_cleared", load_done, 0);
        for (int i = 0; i < 256; i++) put(i, hdr_byte(i, 32'h52434132));
        check("st2_hdr_no_writes", wlog.size(), 0);
        for (int i = 256; i <= 768; i++) put(i, i[7:0] ^ 8'hA5);
        ioctl_download = 1'b0;
        tick(3);
        check("st2_load_done", load_done, 1);
        check("st2_load_error", load_error, 0);
        check("st2_count", wlog.size(), 512);
        if (wlog.size() == 512) begin
            check("st2_first", wlog[0], {12'h400, 8'hA5});
            check("st2_last", wlog[511], {12'h6FF, 8'h5A});
        end
        bad = 0;
        for (int i = 0; i < wlog.size(); i++) begin
            ea = (i < 256) ? 12'h400 + 12'(i) : 12'h600 + 12'(i - 256);
            ed = 8'(i) ^ 8'hA5;
            if (wlog[i] !== {ea, ed}) bad++;
        end
        check("st2_stream", bad, 0);

        // Bad magic "RCA1"
        wlog.delete();
        we_cycles = 0;
        start_load(8'd1);
        for (int i = 0; i < 300; i++) put(i, hdr_byte(i, 32'h52434131));
        check("magic_load_error", load_error, 1);
        check("magic_core_reset", core_reset, 1);
        check("magic_load_done", load_done, 0);
        ioctl_download = 1'b0;
        tick(3);
        check("magic_no_we", we_cycles, 0);
        check("magic_error_kept", load_error, 1);
        check("magic_core_reset_kept", core_reset, 1);

        // Back-pressure with wait obeyed
        wlog.delete();
        start_load(8'd0);
        sent = 0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            mem_if.mem_ready = (cyc >= 10);
            if (cyc == 2) check("bp_wait_two_queued", ioctl_wait, 0);
            if (cyc == 3) check("bp_wait_three_queued", ioctl_wait, 1);
            if (cyc == 6) check("bp_head_hold", {mem_if.mem_we, mem_if.mem_addr, mem_if.mem_data}, {1'b1, 12'h400, 8'h10});
            if (sent < 8 && ioctl_wait == 1'b0) begin
                ioctl_wr   = 1'b1;
                ioctl_addr = 25'(sent);
                ioctl_dout = 8'h10 + 8'(sent);
                sent++;
            end else begin
                ioctl_wr = 1'b0;
            end
            tick(1);
        end
        ioctl_wr = 1'b0;
        check("bp_no_error", load_error, 0);
        ioctl_download = 1'b0;
        tick(3);
        check("bp_load_done", load_done, 1);
        check("bp_count", wlog.size(), 8);
        bad = 0;
        for (int i = 0; i < wlog.size(); i++) begin
            ea = 12'h400 + 12'(i);
            ed = 8'h10 + 8'(i);
            if (wlog[i] !== {ea, ed}) bad++;
        end
        check("bp_order", bad, 0);

        // Source ignores wait: 5th write into a full FIFO
        wlog.delete();
        mem_if.mem_ready = 1'b0;
        start_load(8'd0);
        for (int i = 0; i < 4; i++) put(i, 8'h20 + 8'(i));
        check("ovf_four_ok", load_error, 0);
        check("ovf_wait_high", ioctl_wait, 1);
        put(4, 8'h24);
        check("ovf_error", load_error, 1);
        check("ovf_we_dropped", mem_if.mem_we, 0);
        mem_if.mem_ready = 1'b1;
        tick(3);
        check("ovf_discarded", wlog.size(), 0);
        check("ovf_core_reset", core_reset, 1);
        ioctl_download = 1'b0;
        tick(2);

        // Header truncated at offset 100
        start_load(8'd1);
        for (int i = 0; i <= 100; i++) put(i, hdr_byte(i, 32'h52434132));
        check("trunc_error_cleared", load_error, 0);
        ioctl_download = 1'b0;
        tick(2);
        check("trunc_load_error", load_error, 1);
        check("trunc_core_reset", core_reset, 1);

        // Reset pulsed mid-DATA with 3 entries queued
        mem_if.mem_ready = 1'b0;
        start_load(8'd0);
        for (int i = 0; i < 3; i++) put(i, 8'hA0 + 8'(i));
        check("rstmid_pre_head", {mem_if.mem_we, mem_if.mem_addr, mem_if.mem_data}, {1'b1, 12'h400, 8'hA0});
        #2;
        reset          = 1'b1;
        ioctl_download = 1'b0;
        #1;
        check("rstmid_we_async", mem_if.mem_we, 0);
        check("rstmid_bus", {mem_if.mem_addr, mem_if.mem_data}, 0);
        check("rstmid_core_reset", core_reset, 1);
        tick(2);
        reset = 1'b0;
        mem_if.mem_ready = 1'b1;
        tick(1);
        wlog.delete();
        start_load(8'd0);
        for (int i = 0; i < 4; i++) put(i, 8'hC0 + 8'(i));
        ioctl_download = 1'b0;
        tick(4);
        check("rstmid_reload_done", load_done, 1);
        check("rstmid_reload_error", load_error, 0);
        check("rstmid_reload_count", wlog.size(), 4);
        if (wlog.size() == 4) begin
            check("rstmid_reload_first", wlog[0], {12'h400, 8'hC0});
            check("rstmid_reload_last", wlog[3], {12'h403, 8'hC3});
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
